// File: rtl/jam_pkg.sv
// Shared sizing and types for the job-assignment engine: sequencer,
// cost accumulator and top level all agree on these widths.
package jam_pkg;
    localparam int N_WORK = 8;
    localparam int COST_W = 7;
    localparam int SUM_W  = 10;   // holds N_WORK * (2^COST_W - 1) = 1016
    localparam int CNT_W  = 16;   // holds 8! = 40320

    localparam logic [SUM_W-1:0] MIN_INIT = '1;

    typedef logic [COST_W-1:0] cost_t;
    typedef logic [SUM_W-1:0]  sum_t;
    typedef logic [CNT_W-1:0]  cnt_t;
endpackage

// File: rtl/min_count_tracker.sv
// Running minimum of strobed totals plus a saturating count of how many
// totals hit that minimum.
module min_count_tracker #(
    parameter int SUM_W = jam_pkg::SUM_W,
    parameter int CNT_W = jam_pkg::CNT_W
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             clear,
    input  logic             strobe,
    input  logic [SUM_W-1:0] total,
    output logic [SUM_W-1:0] min_cost,
    output logic [CNT_W-1:0] match_count
);
    // All-ones start means the first strobed total always wins with count 1.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            min_cost    <= '1;
            match_count <= '0;
        end else if (clear) begin
            min_cost    <= '1;
            match_count <= '0;
        end else if (strobe) begin
            if (total < min_cost) begin
                min_cost    <= total;
                match_count <= CNT_W'(1);
            end else if (total == min_cost && match_count != '1) begin
                match_count <= match_count + CNT_W'(1);
            end
        end
    end
endmodule

// File: rtl/cost_accumulator.sv
// Sums each group of N_WORK cost beats into a permutation total, feeds it to
// the min/count tracker, and latches valid once the final permutation lands.
module cost_accumulator #(
    parameter int N_WORK = jam_pkg::N_WORK,
    parameter int COST_W = jam_pkg::COST_W,
    parameter int SUM_W  = jam_pkg::SUM_W,
    parameter int CNT_W  = jam_pkg::CNT_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              clear,
    input  logic [COST_W-1:0] cost,
    input  logic              cost_valid,
    input  logic              perm_last,
    output logic [SUM_W-1:0]  min_cost,
    output logic [CNT_W-1:0]  match_count,
    output logic              valid
);
    localparam logic [2:0] LAST_BEAT = 3'(N_WORK - 1);

    logic [2:0]       beat_cnt;
    logic [SUM_W-1:0] acc;
    logic [SUM_W-1:0] total;
    logic             take;
    logic             done;

    // Once valid is up the stream is ignored, which freezes everything.
    assign take  = cost_valid && !valid;
    assign done  = take && (beat_cnt == LAST_BEAT);
    assign total = acc + SUM_W'(cost);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            beat_cnt <= '0;
            acc      <= '0;
            valid    <= 1'b0;
        end else if (clear) begin
            beat_cnt <= '0;
            acc      <= '0;
            valid    <= 1'b0;
        end else if (take) begin
            if (done) begin
                beat_cnt <= '0;
                acc      <= '0;
                if (perm_last)
                    valid <= 1'b1;
            end else begin
                beat_cnt <= beat_cnt + 3'd1;
                acc      <= total;
            end
        end
    end

    min_count_tracker #(
        .SUM_W (SUM_W),
        .CNT_W (CNT_W)
    ) u_tracker (
        .CLK         (CLK),
        .RST         (RST),
        .clear       (clear),
        .strobe      (done),
        .total       (total),
        .min_cost    (min_cost),
        .match_count (match_count)
    );
endmodule
